// File: rtl/rr_arbiter_param.sv
// N-requester grant arbiter with runtime round-robin / fixed-priority selection,
// grant hold while the owner keeps requesting, and an optional per-ownership burst limit.
module rr_arbiter_param #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 0,
    parameter int ID_W     = $clog2(N)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [N-1:0]    req,
    input  logic            prio_mode,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            gnt_valid,
    output logic            hold_expire
);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    localparam logic [ID_W-1:0] LAST_RST  = ID_W'(N - 1);
    localparam bit              HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [7:0]      HOLD_LAST = HOLD_EN ? 8'(MAX_HOLD - 1) : 8'd0;

    state_t          state_reg, state_next;
    logic [N-1:0]    gnt_reg, gnt_next;
    logic [ID_W-1:0] owner_reg, owner_next;
    logic [ID_W-1:0] last_reg, last_next;
    logic [7:0]      hold_cnt_reg, hold_cnt_next;
    logic            expire_reg, expire_next;

    logic [N-1:0]    owner_mask;
    logic [N-1:0]    cand;
    logic [ID_W:0]   rr_res, fp_res, pick;
    logic            win_found;
    logic [ID_W-1:0] win_id;
    logic            owner_req;

    // Round-robin: first set bit strictly after 'last', wrapping at N-1 (not at 2**ID_W).
    function automatic logic [ID_W:0] rr_pick(input logic [N-1:0] c, input logic [ID_W-1:0] last);
        logic [ID_W:0] res;
        logic [ID_W:0] idx;
        res = '0;
        for (int k = N; k >= 1; k--) begin
            idx = {1'b0, last} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(N))
                idx = idx - (ID_W+1)'(N);
            if (c[idx[ID_W-1:0]])
                res = {1'b1, idx[ID_W-1:0]};
        end
        return res;
    endfunction

    function automatic logic [ID_W:0] fp_pick(input logic [N-1:0] c);
        logic [ID_W:0] res;
        res = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (c[k])
                res = {1'b1, ID_W'(k)};
        end
        return res;
    endfunction

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_owner_mask
            assign owner_mask[gi] = (owner_reg == ID_W'(gi));
        end
    endgenerate

    // While owned, the current owner never competes in a decision.
    assign cand      = (state_reg == OWNED) ? (req & ~owner_mask) : req;
    assign owner_req = |(req & owner_mask);
    assign rr_res    = rr_pick(cand, last_reg);
    assign fp_res    = fp_pick(cand);
    assign pick      = prio_mode ? fp_res : rr_res;
    assign win_found = pick[ID_W];
    assign win_id    = pick[ID_W-1:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= IDLE;
            gnt_reg      <= '0;
            owner_reg    <= '0;
            last_reg     <= LAST_RST;
            hold_cnt_reg <= 8'd0;
            expire_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            gnt_reg      <= gnt_next;
            owner_reg    <= owner_next;
            last_reg     <= last_next;
            hold_cnt_reg <= hold_cnt_next;
            expire_reg   <= expire_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        gnt_next      = gnt_reg;
        owner_next    = owner_reg;
        last_next     = last_reg;
        hold_cnt_next = hold_cnt_reg;
        expire_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                hold_cnt_next = 8'd0;
                if (win_found) begin
                    state_next = OWNED;
                    gnt_next   = N'(1) << win_id;
                    owner_next = win_id;
                    last_next  = win_id;
                end
            end
            OWNED: begin
                if (!owner_req) begin
                    hold_cnt_next = 8'd0;
                    if (win_found) begin
                        gnt_next   = N'(1) << win_id;
                        owner_next = win_id;
                        last_next  = win_id;
                    end else begin
                        state_next = IDLE;
                        gnt_next   = '0;
                        owner_next = '0;
                    end
                end else if (HOLD_EN && (hold_cnt_reg == HOLD_LAST)) begin
                    // Burst limit hit: hand over if anyone else waits, else restart the burst.
                    hold_cnt_next = 8'd0;
                    if (win_found) begin
                        gnt_next    = N'(1) << win_id;
                        owner_next  = win_id;
                        last_next   = win_id;
                        expire_next = 1'b1;
                    end
                end else begin
                    hold_cnt_next = hold_cnt_reg + 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
                owner_next = '0;
            end
        endcase
    end

    always_comb begin
        gnt         = gnt_reg;
        gnt_id      = owner_reg;
        gnt_valid   = (state_reg == OWNED);
        hold_expire = expire_reg;
    end

endmodule

// File: tb/tb_rr_arbiter_param.sv
// Scoreboarded directed checks of rr_arbiter_param (N=4/8) plus a randomized
// property run on an N=5 instance.
module tb_rr_arbiter_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn;
    logic [3:0] req4, gnt4;
    logic [1:0] id4;
    logic       pm4, v4, e4;
    logic [7:0] req8, gnt8;
    logic [2:0] id8;
    logic       pm8, v8, e8;
    logic [4:0] req5, gnt5;
    logic [2:0] id5;
    logic       pm5, v5, e5;

    rr_arbiter_param #(.N(4), .MAX_HOLD(4)) dut4 (
        .clk(clk), .rstn(rstn), .req(req4), .prio_mode(pm4),
        .gnt(gnt4), .gnt_id(id4), .gnt_valid(v4), .hold_expire(e4)
    );
    rr_arbiter_param #(.N(8), .MAX_HOLD(0)) dut8 (
        .clk(clk), .rstn(rstn), .req(req8), .prio_mode(pm8),
        .gnt(gnt8), .gnt_id(id8), .gnt_valid(v8), .hold_expire(e8)
    );
    rr_arbiter_param #(.N(5), .MAX_HOLD(3)) dut5 (
        .clk(clk), .rstn(rstn), .req(req5), .prio_mode(pm5),
        .gnt(gnt5), .gnt_id(id5), .gnt_valid(v5), .hold_expire(e5)
    );

    typedef struct {
        int         sel;
        logic [7:0] g;
        logic [2:0] id;
        logic       v;
        logic       e;
        string      name;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp_v);
        end
    endtask

    function automatic logic [2:0] oh2id(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++)
            if (v[i]) r = 3'(i);
        return r;
    endfunction

    // Drive one request pattern before an edge, then queue what must be visible after it.
    task automatic step(input int sel, input logic [7:0] r, input logic pm,
                        input logic [7:0] eg, input logic ee, input string nm);
        exp_t x;
        @(negedge clk);
        if (sel == 4) begin
            req4 = r[3:0];
            pm4  = pm;
        end else begin
            req8 = r;
            pm8  = pm;
        end
        @(posedge clk);
        x.sel  = sel;
        x.g    = eg;
        x.id   = oh2id(eg);
        x.v    = |eg;
        x.e    = ee;
        x.name = nm;
        sbq.push_back(x);
    endtask

    // Monitor: outputs are stable by the falling edge after the deciding edge.
    initial begin
        exp_t        x;
        logic [12:0] act;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                x = sbq.pop_front();
                if (x.sel == 4) act = {4'b0, gnt4, 1'b0, id4, v4, e4};
                else            act = {gnt8, id8, v8, e8};
                $display("[%0t] %s: gnt=%h id=%0d valid=%b expire=%b", $time, x.name,
                         act[12:5], act[4:2], act[1], act[0]);
                chk(x.name, 32'(act), 32'({x.g, x.id, x.v, x.e}));
            end
        end
    end

    initial begin
        logic [4:0] nr, prev_g;
        int         wait_cnt[5];
        int         bad_oh, bad_nr, bad_id, bad_v, bad_wait, n_chg;

        rstn = 1'b0;
        req4 = '0; req8 = '0; req5 = '0;
        pm4 = 1'b0; pm8 = 1'b0; pm5 = 1'b0;
        #2;
        chk("reset_gnt4", 32'(gnt4), 32'h0);
        chk("reset_valid4", 32'(v4), 32'h0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        step(4, 8'h0, 1'b0, 8'h0, 1'b0, "post_reset4");
        step(8, 8'h0, 1'b0, 8'h0, 1'b0, "post_reset8");

        // Round-robin sequence; each owner drops as the next pattern arrives.
        step(4, 8'b0001, 1'b0, 8'b0001, 1'b0, "rr_0001");
        step(4, 8'b0010, 1'b0, 8'b0010, 1'b0, "rr_0010");
        step(4, 8'b0101, 1'b0, 8'b0100, 1'b0, "rr_0101");
        step(4, 8'b1001, 1'b0, 8'b1000, 1'b0, "rr_1001");
        step(4, 8'b0011, 1'b0, 8'b0001, 1'b0, "rr_0011");
        step(4, 8'b0010, 1'b0, 8'b0010, 1'b0, "rr_0010b");
        step(4, 8'b0000, 1'b0, 8'b0000, 1'b0, "rr_idle");
        step(4, 8'b0000, 1'b0, 8'b0000, 1'b0, "rr_idle2");

        // Burst limit 4 with two contenders, then a lone requester that is re-granted.
        for (int k = 0; k < 16; k++)
            step(4, 8'b0101, 1'b0, (((k / 4) % 2) == 0) ? 8'b0100 : 8'b0001,
                 ((k % 4) == 0) && (k != 0), $sformatf("hold_%0d", k));
        for (int k = 0; k < 12; k++)
            step(4, 8'b0001, 1'b0, 8'b0001, 1'b0, $sformatf("solo_%0d", k));

        // Fixed priority.
        step(4, 8'b1000, 1'b1, 8'b1000, 1'b0, "fp_own3");
        for (int k = 0; k < 3; k++)
            step(4, 8'b1110, 1'b1, 8'b1000, 1'b0, $sformatf("fp_keep_%0d", k));
        step(4, 8'b0110, 1'b1, 8'b0010, 1'b0, "fp_drop3");
        step(4, 8'b0101, 1'b1, 8'b0001, 1'b0, "fp_drop1");
        step(4, 8'b0101, 1'b0, 8'b0001, 1'b0, "mode_no_revoke");
        step(4, 8'b0110, 1'b0, 8'b0010, 1'b0, "rr_resume");
        step(4, 8'b0000, 1'b0, 8'b0000, 1'b0, "fp_idle");

        // N=8 wrap from owner 7 straight to owner 0.
        step(8, 8'h80, 1'b0, 8'h80, 1'b0, "n8_own7");
        step(8, 8'h80, 1'b0, 8'h80, 1'b0, "n8_keep7");
        step(8, 8'h21, 1'b0, 8'h01, 1'b0, "n8_wrap");
        step(8, 8'h20, 1'b0, 8'h20, 1'b0, "n8_next5");
        step(8, 8'h00, 1'b0, 8'h00, 1'b0, "n8_idle");

        // Asynchronous reset in the middle of an ownership (owner 2, hold_cnt 3).
        for (int k = 0; k < 4; k++)
            step(4, 8'b0100, 1'b0, 8'b0100, 1'b0, $sformatf("pre_rst_%0d", k));
        @(negedge clk);
        #2;
        rstn = 1'b0;
        req4 = 4'b1111;
        #1;
        chk("async_rst_gnt", 32'(gnt4), 32'h0);
        chk("async_rst_id", 32'(id4), 32'h0);
        chk("async_rst_valid", 32'(v4), 32'h0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        step(4, 8'b1111, 1'b0, 8'b0001, 1'b0, "after_rst");
        step(4, 8'b1111, 1'b0, 8'b0001, 1'b0, "after_rst_keep");
        step(4, 8'b0000, 1'b0, 8'b0000, 1'b0, "after_rst_idle");

        // Randomized N=5 run checked against invariants and the round-robin wait bound.
        bad_oh = 0; bad_nr = 0; bad_id = 0; bad_v = 0; bad_wait = 0; n_chg = 0;
        prev_g = '0;
        for (int i = 0; i < 5; i++) wait_cnt[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            nr = req5;
            for (int i = 0; i < 5; i++) begin
                if (gnt5[i] && ($urandom_range(3) == 0)) nr[i] = 1'b0;
                else if (!req5[i] && ($urandom_range(2) == 0)) nr[i] = 1'b1;
            end
            req5 = nr;
            @(posedge clk);
            #1;
            if (v5 ? (gnt5 != (5'b1 << id5)) : ((gnt5 != 5'b0) || (id5 != 3'd0))) bad_oh++;
            if ((gnt5 & ~req5) != 5'b0) bad_nr++;
            if (id5 > 3'd4) bad_id++;
            if (v5 != (|gnt5)) bad_v++;
            if (v5 && (gnt5 != prev_g)) n_chg++;
            for (int i = 0; i < 5; i++) begin
                if (!req5[i] || gnt5[i]) wait_cnt[i] = 0;
                else if (v5 && (gnt5 != prev_g)) wait_cnt[i]++;
                if (wait_cnt[i] > 4) bad_wait++;
            end
            prev_g = gnt5;
        end
        chk("rand_onehot", 32'(bad_oh), 32'h0);
        chk("rand_nonreq", 32'(bad_nr), 32'h0);
        chk("rand_id_range", 32'(bad_id), 32'h0);
        chk("rand_valid", 32'(bad_v), 32'h0);
        chk("rand_fair_wait", 32'(bad_wait), 32'h0);
        chk("rand_activity", 32'(n_chg > 500), 32'h1);

        repeat (3) @(negedge clk);
        chk("sb_drain", 32'(sbq.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
